// File: rtl/clk_gate_ctrl.sv
// Per-port clock gating controller with idle hysteresis
// and a round-robin wake arbiter (one wake per cycle).
module clk_gate_ctrl #(
  parameter int NUM_PORTS = 8,
  parameter int CNT_W     = 8,
  parameter int WAKE_CYC  = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] busy,
  input  logic [NUM_PORTS-1:0] wake_req,
  input  logic [NUM_PORTS-1:0] force_on,
  input  logic [CNT_W-1:0]     idle_thresh,
  input  logic                 test_mode,
  output logic [NUM_PORTS-1:0] clk_en,
  output logic [NUM_PORTS-1:0] port_ready,
  output logic [NUM_PORTS-1:0] gated
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_IDLE,
    S_OFF,
    S_WAKE
  } state_t;

  state_t               st_q  [NUM_PORTS];
  state_t               st_d  [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] act, req, gnt;
  logic [NUM_PORTS-1:0] en_q, en_d;
  logic [NUM_PORTS-1:0] rdy_q, rdy_d;
  logic [NUM_PORTS-1:0] off_q, off_d;
  logic                 thr_zero;
  logic [CNT_W-1:0]     thr_m1;

  // ptr holds the last granted port; search begins just after it
  function automatic logic [NUM_PORTS-1:0] rr_pick(
    input logic [NUM_PORTS-1:0] r,
    input logic [PW-1:0]        last
  );
    logic [NUM_PORTS-1:0] g;
    int idx;
    g = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (g == '0 && r[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  always_comb begin
    act      = busy | wake_req | force_on;
    thr_zero = (idle_thresh == '0);
    thr_m1   = idle_thresh - CNT_W'(1);
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = (st_q[i] == S_OFF) && act[i];
    end
    gnt   = rr_pick(req, ptr_q);
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) ptr_d = PW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        S_RUN: begin
          if (!act[i] && !thr_zero) begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
          end
        end
        S_IDLE: begin
          if (act[i] || thr_zero) begin
            st_d[i] = S_RUN;
          end else if (cnt_q[i] >= thr_m1) begin
            st_d[i] = S_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        S_OFF: begin
          if (gnt[i]) begin
            st_d[i]  = S_WAKE;
            cnt_d[i] = '0;
          end
        end
        S_WAKE: begin
          if (int'(cnt_q[i]) >= WAKE_CYC - 1) begin
            st_d[i] = S_RUN;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: st_d[i] = S_RUN;
      endcase
      en_d[i]  = (st_d[i] != S_OFF);
      rdy_d[i] = (st_d[i] == S_RUN) || (st_d[i] == S_IDLE);
      off_d[i] = (st_d[i] == S_OFF);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        st_q[i]  <= S_RUN;
        cnt_q[i] <= '0;
      end
      ptr_q <= '0;
      en_q  <= '1;
      rdy_q <= '1;
      off_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ptr_q <= ptr_d;
      en_q  <= en_d;
      rdy_q <= rdy_d;
      off_q <= off_d;
    end
  end

  // DFT override bypasses the registers but never touches FSM state
  assign clk_en     = en_q | {NUM_PORTS{test_mode}};
  assign port_ready = rdy_q;
  assign gated      = off_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios then random
// traffic against an abstract per-port reference model.
module tb_clk_gate_ctrl;

  localparam int NP   = 8;
  localparam int CW   = 8;
  localparam int WAKE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] busy, wake_req, force_on;
  logic [CW-1:0] idle_thresh;
  logic          test_mode;
  logic [NP-1:0] clk_en, port_ready, gated;

  int tests = 0;
  int fails = 0;

  // model: off flag, wake cycles remaining, inactive run length
  bit m_off  [NP];
  int m_wl   [NP];
  int m_run  [NP];
  int m_last;

  clk_gate_ctrl #(
    .NUM_PORTS(NP),
    .CNT_W(CW),
    .WAKE_CYC(WAKE)
  ) dut (
    .clk_in(clk),
    .rst(rst),
    .busy(busy),
    .wake_req(wake_req),
    .force_on(force_on),
    .idle_thresh(idle_thresh),
    .test_mode(test_mode),
    .clk_en(clk_en),
    .port_ready(port_ready),
    .gated(gated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [NP-1:0] act;
    int g, idx;
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        m_off[i] = 0; m_wl[i] = 0; m_run[i] = 0;
      end
      m_last = 0;
    end else begin
      act = busy | wake_req | force_on;
      g = -1;
      for (int k = 1; k <= NP; k++) begin
        idx = (m_last + k) % NP;
        if (g < 0 && m_off[idx] && act[idx]) g = idx;
      end
      if (g >= 0) m_last = g;
      for (int i = 0; i < NP; i++) begin
        if (m_off[i]) begin
          if (i == g) begin
            m_off[i] = 0; m_wl[i] = WAKE; m_run[i] = 0;
          end
        end else if (m_wl[i] > 0) begin
          m_wl[i]--;
        end else if (act[i] || idle_thresh == 0) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] >= int'(idle_thresh) + 1) begin
            m_off[i] = 1; m_run[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [NP-1:0] e_en, e_rdy, e_off;
    for (int i = 0; i < NP; i++) begin
      e_off[i] = m_off[i];
      e_en[i]  = !m_off[i] || test_mode;
      e_rdy[i] = !m_off[i] && (m_wl[i] == 0);
    end
    chk({tag, ".clk_en"}, 32'(clk_en), 32'(e_en));
    chk({tag, ".ready"}, 32'(port_ready), 32'(e_rdy));
    chk({tag, ".gated"}, 32'(gated), 32'(e_off));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; busy = '1; wake_req = '0; force_on = '0;
    idle_thresh = 8'd3; test_mode = 1'b0;
    @(negedge clk);
    tick("reset");
    chk("reset_en", 32'(clk_en), 32'hFF);
    chk("reset_rdy", 32'(port_ready), 32'hFF);
    chk("reset_gated", 32'(gated), 32'h00);
    rst = 1'b0;
    tick("run");
    tick("run");

    // gate port 0 with threshold 3
    busy[0] = 1'b0;
    tick("gate_k");
    tick("gate_k1");
    tick("gate_k2");
    chk("gate_before", 32'(gated), 32'h00);
    tick("gate_k3");
    chk("gate_en", 32'(clk_en), 32'hFE);
    chk("gate_gated", 32'(gated), 32'h01);

    // wake port 0
    wake_req[0] = 1'b1;
    tick("wake_j");
    chk("wake_en_j", 32'(clk_en[0]), 32'h1);
    chk("wake_rdy_j", 32'(port_ready[0]), 32'h0);
    tick("wake_j1");
    chk("wake_rdy_j1", 32'(port_ready[0]), 32'h0);
    tick("wake_j2");
    chk("wake_rdy_j2", 32'(port_ready[0]), 32'h1);
    wake_req[0] = 1'b0;
    busy[0] = 1'b1;
    tick("wake_hold");

    // all ports off, then ports 1,3,6 request together
    busy = '0; idle_thresh = 8'd1;
    repeat (3) tick("all_off");
    chk("all_off_gated", 32'(gated), 32'hFF);
    wake_req = 8'h4A;
    tick("arb1");
    chk("arb_g1", 32'(gated), 32'hFD);
    tick("arb2");
    chk("arb_g3", 32'(gated), 32'hF5);
    tick("arb3");
    chk("arb_g6", 32'(gated), 32'hB5);
    wake_req = '0;
    repeat (6) tick("regate");
    chk("regate_gated", 32'(gated), 32'hFF);

    // test_mode forces clocks without touching state
    test_mode = 1'b1;
    #1;
    chk("tm_en", 32'(clk_en), 32'hFF);
    chk("tm_gated", 32'(gated), 32'hFF);
    tick("tm_hold");
    chk("tm_gated2", 32'(gated), 32'hFF);
    test_mode = 1'b0;
    #1;
    chk("tm_off_en", 32'(clk_en), 32'h00);

    // force_on keeps port 2 running
    force_on[2] = 1'b1;
    repeat (8) tick("force");
    chk("force_rdy2", 32'(port_ready[2]), 32'h1);
    force_on[2] = 1'b0;

    // wake all, then thresh 0 disables gating
    busy = '1;
    repeat (14) tick("wake_all");
    idle_thresh = 8'd0; busy = '0;
    repeat (6) tick("thr0");
    chk("thr0_gated", 32'(gated), 32'h00);
    chk("thr0_rdy", 32'(port_ready), 32'hFF);

    // busy returns exactly when cnt = thresh-1
    idle_thresh = 8'd3; busy = '1;
    tick("col_pre");
    busy[0] = 1'b0;
    repeat (3) tick("col_idle");
    busy[0] = 1'b1;
    tick("col_hit");
    chk("col_gated", 32'(gated[0]), 32'h0);
    chk("col_rdy", 32'(port_ready[0]), 32'h1);
    repeat (3) tick("col_after");
    chk("col_after_g", 32'(gated[0]), 32'h0);

    // reset mid-wake
    busy = '0; idle_thresh = 8'd1;
    repeat (3) tick("rw_off");
    wake_req = 8'h01;
    tick("rw_grant");
    rst = 1'b1;
    tick("rw_rst");
    chk("rw_en", 32'(clk_en), 32'hFF);
    chk("rw_rdy", 32'(port_ready), 32'hFF);
    chk("rw_gated", 32'(gated), 32'h00);
    rst = 1'b0; wake_req = '0;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      busy     = NP'($urandom) & NP'($urandom);
      wake_req = NP'($urandom) & NP'($urandom) & NP'($urandom);
      force_on = ($urandom_range(0, 9) == 0) ? NP'($urandom) : '0;
      if ($urandom_range(0, 19) == 0) idle_thresh = CW'($urandom_range(0, 4));
      test_mode = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
